rob: RTL and testbench
======================

# rob

Reorder buffer for the 2-wide out-of-order core: the producer of the dispatch count and retire tags that the free list consumes. Each cycle it accepts up to two dispatched instructions, tagged with their new and overwritten physical registers. It records completions from the CDB and retires up to two instructions in program order. On retire it returns each instruction's overwritten physical register to the free list.

## Interface
- `ROB_SIZE`, 32: entries; must be a power of two.
- `IDX_W`, 5: log2(`ROB_SIZE`).
- `clock` in 1: single clock, posedge.
- `reset` in 1: asynchronous, active-high.
- `id_dispatch_num` in 2: instructions offered by decode this cycle (0–2; 3 is treated as 2).
- `fl_pr0`, `fl_pr1` in 7: new physical tags from the free list (`rob_rs_mt_pr0/1`).
- `mt_old_pr0`, `mt_old_pr1` in 7: physical tags being overwritten, from the map table.
- `cdb_valid_0`, `cdb_valid_1` in 1: completion broadcasts.
- `cdb_rob_idx_0`, `cdb_rob_idx_1` in `IDX_W`: completing entry index.
- `rob_dispatch_num` out 2: instructions accepted this cycle; drives the free list.
- `rob_idx0`, `rob_idx1` out `IDX_W`: indices assigned to slots 0 and 1.
- `rob_retire_num` out 2: instructions retiring this cycle (0–2).
- `rob_retire_tag_0`, `rob_retire_tag_1` out 7: old tags freed (tag_0 is the older).
- `rob_full`, `rob_empty` out 1: status.
- `rob_count` out `IDX_W`+1: occupied entries.

## Operation
**State**
- `head` and `tail` pointers, each `IDX_W` bits, wrapping modulo `ROB_SIZE`.
- `count` register, `IDX_W`+1 bits.
- Per entry: `valid`, `complete`, `new_pr[6:0]`, `old_pr[6:0]`.

**Dispatch** (combinational accept, registered write)
- `free = ROB_SIZE - count`, using the registered count only. Same-cycle retires do not create space.
- `rob_dispatch_num = min(id_dispatch_num clamped to 2, free)`.
- `rob_idx0 = tail`, `rob_idx1 = tail+1` (mod `ROB_SIZE`). These are driven regardless of acceptance.
- Each accepted slot k writes at posedge: entry `tail+k` gets `valid=1`, `complete=0`, `new_pr=fl_prk`, `old_pr=mt_old_prk`.
- `tail` advances by `rob_dispatch_num`.

**Completion**
- A valid CDB broadcast sets `complete` on its indexed entry at posedge, only if that entry is `valid`.
- A broadcast to an invalid entry is ignored.
- If a same-cycle dispatch writes the same index, the dispatch wins and `complete=0`.
- Both CDB ports may target the same index; the result is still `complete=1`.

**Retire** (in order, from registered state only, so there is no combinational loop with the free list)
- `r0 = valid[head] & complete[head]`.
- `r1 = r0 & valid[head+1] & complete[head+1]`.
- `rob_retire_num = r0 + r1`.
- `rob_retire_tag_0 = old_pr[head]` when r0, else 0.
- `rob_retire_tag_1 = old_pr[head+1]` when r1, else 0.
- At posedge, retired entries get `valid=0` and `complete=0`, and `head` advances by `rob_retire_num`.
- A completed entry behind an incomplete head never retires.

**Count and status**
- `count <= count + rob_dispatch_num - rob_retire_num`.
- `rob_full = (count == ROB_SIZE)`; `rob_empty = (count == 0)`.

**Reset**
- While `reset` is high, asynchronously: `head=tail=0`, `count=0`, all `valid` and `complete` cleared.
- All outputs are forced: `rob_dispatch_num=0`, `rob_retire_num=0`, retire tags 0, `rob_idx0=0`, `rob_idx1=1`, `rob_empty=1`, `rob_full=0`, `rob_count=0`.
- Entry payload registers need no reset.

## Timing
- **Dispatch accept:** zero latency; `rob_dispatch_num` is combinational from `id_dispatch_num` and `count`. Written entries are visible the next cycle.
- **Completion to retire:** a CDB broadcast in cycle N makes the entry retire-eligible in cycle N+1 at the earliest. `rob_retire_num` asserts in N+1 if the entry is at head.
- **Retire outputs:** stable from clock-to-q; they depend only on registered state.
- **Simultaneous dispatch 2 and retire 2 when full:** accept 0 (free is 0), retire 2; count goes 32 → 30.
- **Wrap-around:** pointer arithmetic is mod `ROB_SIZE`. Slot 1 at tail 31 maps to index 0. `count` distinguishes full from empty when `head == tail`.
- **Reset mid-operation:** in-flight entries are discarded immediately. The first post-reset dispatch lands at index 0.

## Test plan
1. **Reset:** assert `reset` at an arbitrary point mid-run → same cycle `rob_empty=1`, `rob_full=0`, `rob_count=0`, `rob_retire_num=0`, `rob_dispatch_num=0` even with `id_dispatch_num=2`.
2. **In-order retire:** dispatch 2 with `mt_old_pr0=40`, `mt_old_pr1=41` (`rob_idx0=0`, `rob_idx1=1`). CDB completes idx 1 → `rob_retire_num` stays 0. CDB completes idx 0 → next cycle `rob_retire_num=2`, tag_0=40, tag_1=41; the cycle after that, `rob_empty=1`.
3. **Fill:** 16 cycles of `id_dispatch_num=2` with no completions → `rob_count=32`, `rob_full=1`; a further request of 2 → `rob_dispatch_num=0`, `tail` unchanged.
4. **Partial accept:** `rob_count=31`, request 2 → `rob_dispatch_num=1`, only entry `tail` written, then `rob_full=1`.
5. **Wrap:** advance head and tail to 31; dispatch 2 → `rob_idx0=31`, `rob_idx1=0`. Complete both → `rob_retire_num=2` with tags in order 31 then 0; pointers end at 1.
6. **Mixed cycle:** head complete and head+1 incomplete, `id_dispatch_num=2`, `count=10` → `rob_retire_num=1`, `rob_dispatch_num=2`, next `rob_count=11`. A CDB hit on an invalid index → no state change.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer for the 2-wide out-of-order core.
// Accepts up to two dispatches per cycle, records CDB completions, and retires up to two instructions in program order.
module rob #(
  parameter int ROB_SIZE = 32,
  parameter int IDX_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       id_dispatch_num,
  input  logic [6:0]       fl_pr0,
  input  logic [6:0]       fl_pr1,
  input  logic [6:0]       mt_old_pr0,
  input  logic [6:0]       mt_old_pr1,
  input  logic             cdb_valid_0,
  input  logic             cdb_valid_1,
  input  logic [IDX_W-1:0] cdb_rob_idx_0,
  input  logic [IDX_W-1:0] cdb_rob_idx_1,
  output logic [1:0]       rob_dispatch_num,
  output logic [IDX_W-1:0] rob_idx0,
  output logic [IDX_W-1:0] rob_idx1,
  output logic [1:0]       rob_retire_num,
  output logic [6:0]       rob_retire_tag_0,
  output logic [6:0]       rob_retire_tag_1,
  output logic             rob_full,
  output logic             rob_empty,
  output logic [IDX_W:0]   rob_count
);

  localparam int CNT_W = IDX_W + 1;

  logic [IDX_W-1:0]    head, tail, head1, tail1;
  logic [CNT_W-1:0]    count, free;
  logic [ROB_SIZE-1:0] valid, complete;
  logic [6:0]          new_pr [ROB_SIZE];
  logic [6:0]          old_pr [ROB_SIZE];
  logic [1:0]          req, disp, ret;
  logic                r0, r1;

  assign head1 = head + IDX_W'(1);
  assign tail1 = tail + IDX_W'(1);

  // Accept is limited by registered occupancy only; same-cycle retires do not free space.
  always_comb begin
    req  = (id_dispatch_num == 2'd3) ? 2'd2 : id_dispatch_num;
    free = CNT_W'(ROB_SIZE) - count;
    disp = req;
    if (CNT_W'(req) > free) disp = free[1:0];
    if (reset) disp = 2'd0;
  end

  // Retire looks only at registered state so the free list sees no combinational path back.
  assign r0  = valid[head] & complete[head];
  assign r1  = r0 & valid[head1] & complete[head1];
  assign ret = {1'b0, r0} + {1'b0, r1};

  assign rob_dispatch_num = disp;
  assign rob_retire_num   = ret;
  assign rob_retire_tag_0 = r0 ? old_pr[head]  : 7'd0;
  assign rob_retire_tag_1 = r1 ? old_pr[head1] : 7'd0;
  assign rob_idx0         = tail;
  assign rob_idx1         = tail1;
  assign rob_count        = count;
  assign rob_full         = (count == CNT_W'(ROB_SIZE));
  assign rob_empty        = (count == '0);

  // NOTE: non-blocking assignments; later writes to the same bit override earlier ones,
  // giving the priority dispatch > retire > completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      complete <= '0;
    end else begin
      head  <= head + IDX_W'(ret);
      tail  <= tail + IDX_W'(disp);
      count <= count + CNT_W'(disp) - CNT_W'(ret);
      if (cdb_valid_0 && valid[cdb_rob_idx_0]) complete[cdb_rob_idx_0] <= 1'b1;
      if (cdb_valid_1 && valid[cdb_rob_idx_1]) complete[cdb_rob_idx_1] <= 1'b1;
      if (r0) begin
        valid[head]    <= 1'b0;
        complete[head] <= 1'b0;
      end
      if (r1) begin
        valid[head1]    <= 1'b0;
        complete[head1] <= 1'b0;
      end
      if (disp != 2'd0) begin
        valid[tail]    <= 1'b1;
        complete[tail] <= 1'b0;
      end
      if (disp == 2'd2) begin
        valid[tail1]    <= 1'b1;
        complete[tail1] <= 1'b0;
      end
    end
  end

  // NOTE: payload arrays have no reset; valid gates every read, so their contents never leak.
  always_ff @(posedge clock) begin
    if (disp != 2'd0) begin
      new_pr[tail] <= fl_pr0;
      old_pr[tail] <= mt_old_pr0;
    end
    if (disp == 2'd2) begin
      new_pr[tail1] <= fl_pr1;
      old_pr[tail1] <= mt_old_pr1;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: a reference occupancy model plus a queue of old tags
// in program order that retire outputs are popped against.
module tb_rob;
  localparam int N = 32;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] id_dispatch_num;
  logic [6:0] fl_pr0, fl_pr1, mt_old_pr0, mt_old_pr1;
  logic       cdb_valid_0, cdb_valid_1;
  logic [4:0] cdb_rob_idx_0, cdb_rob_idx_1;
  logic [1:0] rob_dispatch_num, rob_retire_num;
  logic [4:0] rob_idx0, rob_idx1;
  logic [6:0] rob_retire_tag_0, rob_retire_tag_1;
  logic       rob_full, rob_empty;
  logic [5:0] rob_count;

  int checks = 0;
  int failures = 0;

  bit m_valid [N];
  bit m_comp  [N];
  int m_head, m_tail, m_count;
  logic [6:0] exp_q [$];

  rob #(.ROB_SIZE(N), .IDX_W(5)) dut (
    .clock(clock), .reset(reset), .id_dispatch_num(id_dispatch_num),
    .fl_pr0(fl_pr0), .fl_pr1(fl_pr1), .mt_old_pr0(mt_old_pr0), .mt_old_pr1(mt_old_pr1),
    .cdb_valid_0(cdb_valid_0), .cdb_valid_1(cdb_valid_1),
    .cdb_rob_idx_0(cdb_rob_idx_0), .cdb_rob_idx_1(cdb_rob_idx_1),
    .rob_dispatch_num(rob_dispatch_num), .rob_idx0(rob_idx0), .rob_idx1(rob_idx1),
    .rob_retire_num(rob_retire_num), .rob_retire_tag_0(rob_retire_tag_0),
    .rob_retire_tag_1(rob_retire_tag_1), .rob_full(rob_full), .rob_empty(rob_empty),
    .rob_count(rob_count)
  );

  always #5 clock = ~clock;

  task automatic set_in(input int d, input int o0, input int o1,
                        input bit cv0, input int ci0, input bit cv1, input int ci1);
    id_dispatch_num = 2'(d);
    mt_old_pr0 = 7'(o0);
    mt_old_pr1 = 7'(o1);
    fl_pr0 = 7'(o0 + 64);
    fl_pr1 = 7'(o1 + 64);
    cdb_valid_0 = cv0;
    cdb_rob_idx_0 = 5'(ci0);
    cdb_valid_1 = cv1;
    cdb_rob_idx_1 = 5'(ci1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_comp[i] = 1'b0;
    end
    m_head = 0;
    m_tail = 0;
    m_count = 0;
    exp_q.delete();
  endtask

  // One clock cycle: compare every output against the model, then advance model and DUT.
  task automatic tick();
    int req, acc, ret, h1;
    bit r0, r1;
    logic [6:0] e0, e1;
    #1;
    req = (id_dispatch_num == 2'd3) ? 2 : int'(id_dispatch_num);
    acc = (req < N - m_count) ? req : N - m_count;
    h1 = (m_head + 1) % N;
    r0 = m_valid[m_head] && m_comp[m_head];
    r1 = r0 && m_valid[h1] && m_comp[h1];
    ret = int'(r0) + int'(r1);
    e0 = 7'd0;
    e1 = 7'd0;
    if (r0 && exp_q.size() > 0) e0 = exp_q.pop_front();
    if (r1 && exp_q.size() > 0) e1 = exp_q.pop_front();
    checks++; if (rob_dispatch_num !== 2'(acc)) begin failures++; $display("FAIL dispatch_num: got %0d expected %0d", rob_dispatch_num, acc); end
    checks++; if (rob_retire_num !== 2'(ret)) begin failures++; $display("FAIL retire_num: got %0d expected %0d", rob_retire_num, ret); end
    checks++; if (rob_retire_tag_0 !== e0) begin failures++; $display("FAIL retire_tag_0: got %0d expected %0d", rob_retire_tag_0, e0); end
    checks++; if (rob_retire_tag_1 !== e1) begin failures++; $display("FAIL retire_tag_1: got %0d expected %0d", rob_retire_tag_1, e1); end
    checks++; if (rob_idx0 !== 5'(m_tail) || rob_idx1 !== 5'((m_tail + 1) % N)) begin failures++; $display("FAIL idx: got %0d/%0d expected %0d/%0d", rob_idx0, rob_idx1, m_tail, (m_tail + 1) % N); end
    checks++; if (rob_count !== 6'(m_count) || rob_full !== (m_count == N) || rob_empty !== (m_count == 0)) begin failures++; $display("FAIL status: got count=%0d full=%0b empty=%0b expected count=%0d", rob_count, rob_full, rob_empty, m_count); end
    if (acc >= 1) exp_q.push_back(mt_old_pr0);
    if (acc == 2) exp_q.push_back(mt_old_pr1);
    if (cdb_valid_0 && m_valid[cdb_rob_idx_0]) m_comp[cdb_rob_idx_0] = 1'b1;
    if (cdb_valid_1 && m_valid[cdb_rob_idx_1]) m_comp[cdb_rob_idx_1] = 1'b1;
    if (r0) begin m_valid[m_head] = 1'b0; m_comp[m_head] = 1'b0; end
    if (r1) begin m_valid[h1] = 1'b0; m_comp[h1] = 1'b0; end
    for (int k = 0; k < acc; k++) begin
      m_valid[(m_tail + k) % N] = 1'b1;
      m_comp[(m_tail + k) % N] = 1'b0;
    end
    m_head = (m_head + ret) % N;
    m_tail = (m_tail + acc) % N;
    m_count = m_count + acc - ret;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Completes every valid entry two per cycle, then waits (bounded) until the buffer drains.
  task automatic drain();
    int budget;
    for (int i = 0; i < N; i += 2) begin
      set_in(0, 0, 0, 1, i, 1, i + 1);
      tick();
    end
    idle();
    budget = 40;
    while (m_count != 0 && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (budget == 0) begin failures++; $display("FAIL drain_timeout: got count=%0d expected 0", m_count); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(2, 1, 2, 0, 0, 0, 0);
    #2;
    checks++;
    if (rob_empty !== 1'b1 || rob_full !== 1'b0 || rob_count !== 6'd0 || rob_retire_num !== 2'd0 ||
        rob_dispatch_num !== 2'd0 || rob_idx0 !== 5'd0 || rob_idx1 !== 5'd1 ||
        rob_retire_tag_0 !== 7'd0 || rob_retire_tag_1 !== 7'd0) begin
      failures++;
      $display("FAIL reset_outputs: got empty=%0b full=%0b count=%0d ret=%0d disp=%0d idx=%0d/%0d expected 1 0 0 0 0 0/1",
               rob_empty, rob_full, rob_count, rob_retire_num, rob_dispatch_num, rob_idx0, rob_idx1);
    end
    model_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    idle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_in_order();
    set_in(2, 40, 41, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 1, 1, 0, 0);
    tick();
    checks++; if (rob_retire_num !== 2'd0) begin failures++; $display("FAIL no_retire_past_head: got %0d expected 0", rob_retire_num); end
    set_in(0, 0, 0, 1, 0, 0, 0);
    tick();
    idle();
    checks++;
    if (rob_retire_num !== 2'd2 || rob_retire_tag_0 !== 7'd40 || rob_retire_tag_1 !== 7'd41) begin
      failures++;
      $display("FAIL in_order_retire: got %0d tags %0d,%0d expected 2 tags 40,41", rob_retire_num, rob_retire_tag_0, rob_retire_tag_1);
    end
    tick();
    checks++; if (rob_empty !== 1'b1) begin failures++; $display("FAIL empty_after_retire: got %0b expected 1", rob_empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      set_in(2, 2 * i, 2 * i + 1, 0, 0, 0, 0);
      tick();
    end
    checks++; if (rob_count !== 6'd32 || rob_full !== 1'b1) begin failures++; $display("FAIL fill: got count=%0d full=%0b expected 32 1", rob_count, rob_full); end
    set_in(3, 90, 91, 0, 0, 0, 0);
    tick();
    checks++; if (rob_idx0 !== 5'd2) begin failures++; $display("FAIL tail_held_when_full: got %0d expected 2", rob_idx0); end
  endtask

  task automatic test_full_retire_partial();
    set_in(0, 0, 0, 1, m_head, 1, (m_head + 1) % N);
    tick();
    set_in(2, 92, 93, 0, 0, 0, 0);
    tick();
    checks++; if (rob_count !== 6'd30) begin failures++; $display("FAIL full_retire_count: got %0d expected 30", rob_count); end
    set_in(1, 94, 0, 0, 0, 0, 0);
    tick();
    set_in(2, 95, 96, 0, 0, 0, 0);
    tick();
    checks++; if (rob_full !== 1'b1) begin failures++; $display("FAIL partial_accept_full: got %0b expected 1", rob_full); end
    drain();
  endtask

  task automatic test_mixed();
    for (int i = 0; i < 5; i++) begin
      set_in(2, 50 + 2 * i, 51 + 2 * i, 0, 0, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 1, m_head, 0, 0);
    tick();
    set_in(2, 60, 61, 1, (m_tail + 5) % N, 0, 0);
    tick();
    checks++; if (rob_count !== 6'd11) begin failures++; $display("FAIL mixed_count: got %0d expected 11", rob_count); end
    set_in(1, 62, 0, 1, m_tail, 1, (m_head + 1) % N);
    tick();
    idle();
    tick();
    tick();
    // mid-run reset with a dispatch request pending
    reset = 1'b1;
    set_in(2, 70, 71, 0, 0, 0, 0);
    #2;
    checks++;
    if (rob_empty !== 1'b1 || rob_count !== 6'd0 || rob_dispatch_num !== 2'd0 || rob_retire_num !== 2'd0 || rob_full !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: got empty=%0b count=%0d disp=%0d ret=%0d full=%0b expected 1 0 0 0 0",
               rob_empty, rob_count, rob_dispatch_num, rob_retire_num, rob_full);
    end
    model_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    idle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_wrap();
    checks++; if (rob_idx0 !== 5'd0) begin failures++; $display("FAIL post_reset_idx: got %0d expected 0", rob_idx0); end
    for (int i = 0; i < 15; i++) begin
      set_in(2, 2 * i, 2 * i + 1, 0, 0, 0, 0);
      tick();
    end
    set_in(1, 30, 0, 0, 0, 0, 0);
    tick();
    drain();
    checks++; if (rob_idx0 !== 5'd31 || rob_idx1 !== 5'd0) begin failures++; $display("FAIL wrap_idx: got %0d/%0d expected 31/0", rob_idx0, rob_idx1); end
    set_in(2, 100, 101, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 1, 0, 1, 31);
    tick();
    idle();
    checks++;
    if (rob_retire_num !== 2'd2 || rob_retire_tag_0 !== 7'd100 || rob_retire_tag_1 !== 7'd101) begin
      failures++;
      $display("FAIL wrap_retire: got %0d tags %0d,%0d expected 2 tags 100,101", rob_retire_num, rob_retire_tag_0, rob_retire_tag_1);
    end
    tick();
    checks++; if (rob_idx0 !== 5'd1 || rob_empty !== 1'b1) begin failures++; $display("FAIL wrap_end: got idx0=%0d empty=%0b expected 1 1", rob_idx0, rob_empty); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_fill();
    test_full_retire_partial();
    test_mixed();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
